// File: rtl/ariane_pkg.sv
// ariane_pkg: shared types for the issue path.
//   scoreboard_entry_t : decoded instruction as tracked by the scoreboard
//   issue_q_entry_t    : one issue-queue slot (entry + control-flow flag)
package ariane_pkg;

  typedef struct packed {
    logic [63:0] pc;
    logic [2:0]  trans_id;
    logic [3:0]  fu;
    logic [7:0]  op;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [63:0] result;
    logic        valid;
    logic        use_imm;
    logic        use_zimm;
    logic        use_pc;
  } scoreboard_entry_t;

  typedef struct packed {
    scoreboard_entry_t sbe;
    logic              is_ctrl_flow;
  } issue_q_entry_t;

endpackage

// File: rtl/issue_entry_queue.sv
// issue_entry_queue: in-order DEPTH-entry FIFO between decode and issue.
//   Decoder side : decoded_instr_i / decoded_instr_valid_i / is_ctrl_flow_i,
//                  decoded_instr_ack_o (accepted this cycle)
//   Issue side   : issue_entry_o / issue_entry_valid_o / is_ctrl_flow_o (head),
//                  issue_instr_ack_i (head consumed this cycle)
//   Lookahead    : peek_entry_o / peek_valid_o (second-oldest entry)
//   Status       : count_o occupancy
//   flush_i drops all entries on the next edge (storage left as is).
// Build option ISSUE_QUEUE_BYPASS_EN: when empty, the decoder entry is
// presented combinationally on the issue outputs; if consumed in the same
// cycle it is never written.
module issue_entry_queue
  import ariane_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       flush_i,
  input  scoreboard_entry_t          decoded_instr_i,
  input  logic                       decoded_instr_valid_i,
  input  logic                       is_ctrl_flow_i,
  output logic                       decoded_instr_ack_o,
  output scoreboard_entry_t          issue_entry_o,
  output logic                       issue_entry_valid_o,
  output logic                       is_ctrl_flow_o,
  input  logic                       issue_instr_ack_i,
  output scoreboard_entry_t          peek_entry_o,
  output logic                       peek_valid_o,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  issue_q_entry_t          mem_q [DEPTH];
  logic [PTR_W-1:0]        rptr_q, wptr_q, rptr_nxt;
  logic [CNT_W-1:0]        count_q;
  logic                    full, empty;
  logic                    push, pop, acc;
  issue_q_entry_t          head, peek;

  assign full     = (count_q == FULL_CNT);
  assign empty    = (count_q == '0);
  assign rptr_nxt = rptr_q + PTR_W'(1);
  assign head     = mem_q[rptr_q];
  assign peek     = mem_q[rptr_nxt];

  // Acceptance depends on registered occupancy only, so a pop in the same
  // cycle never frees a slot for the incoming entry.
  assign acc = decoded_instr_valid_i & ~full & ~flush_i;
  assign decoded_instr_ack_o = acc;

`ifdef ISSUE_QUEUE_BYPASS_EN
  logic byp_take;
  // Empty queue: the decoder entry is the head. Flush gates validity so a
  // dropped entry can never be issued without being acked to the decoder.
  assign byp_take = empty & acc & issue_instr_ack_i;
  assign push     = acc & ~byp_take;
  assign pop      = issue_instr_ack_i & ~empty & ~flush_i;

  always_comb begin
    issue_entry_o       = head.sbe;
    is_ctrl_flow_o      = head.is_ctrl_flow;
    issue_entry_valid_o = ~empty;
    if (empty) begin
      issue_entry_o       = decoded_instr_i;
      is_ctrl_flow_o      = is_ctrl_flow_i;
      issue_entry_valid_o = decoded_instr_valid_i & ~flush_i;
    end
  end
`else
  assign push = acc;
  // Ack on an empty queue is ignored; flush overrides a pop.
  assign pop  = issue_instr_ack_i & ~empty & ~flush_i;

  assign issue_entry_o       = head.sbe;
  assign is_ctrl_flow_o      = head.is_ctrl_flow;
  assign issue_entry_valid_o = ~empty;
`endif

  assign peek_entry_o = peek.sbe;
  assign peek_valid_o = (count_q >= CNT_W'(2));
  assign count_o      = count_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rptr_q  <= '0;
      wptr_q  <= '0;
      count_q <= '0;
    end else if (flush_i) begin
      rptr_q  <= '0;
      wptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (push) wptr_q <= wptr_q + PTR_W'(1);
      if (pop)  rptr_q <= rptr_nxt;
      case ({push, pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage is cleared only by reset; flush just rewinds the pointers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
    end else if (push) begin
      mem_q[wptr_q] <= '{sbe: decoded_instr_i, is_ctrl_flow: is_ctrl_flow_i};
    end
  end

endmodule

// File: tb/tb_issue_entry_queue.sv
// tb_issue_entry_queue: directed self-checking bench for issue_entry_queue
// (DEPTH=4). Handles both builds of ISSUE_QUEUE_BYPASS_EN.
module tb_issue_entry_queue;
  import ariane_pkg::*;

  localparam int DEPTH = 4;
`ifdef ISSUE_QUEUE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic              clk_i = 1'b0;
  logic              rst_ni;
  logic              flush_i;
  scoreboard_entry_t decoded_instr_i;
  logic              decoded_instr_valid_i;
  logic              is_ctrl_flow_i;
  logic              decoded_instr_ack_o;
  scoreboard_entry_t issue_entry_o;
  logic              issue_entry_valid_o;
  logic              is_ctrl_flow_o;
  logic              issue_instr_ack_i;
  scoreboard_entry_t peek_entry_o;
  logic              peek_valid_o;
  logic [2:0]        count_o;

  int n_chk = 0;
  int n_err = 0;

  issue_entry_queue #(.DEPTH(DEPTH)) dut (
    .clk_i                 (clk_i),
    .rst_ni                (rst_ni),
    .flush_i               (flush_i),
    .decoded_instr_i       (decoded_instr_i),
    .decoded_instr_valid_i (decoded_instr_valid_i),
    .is_ctrl_flow_i        (is_ctrl_flow_i),
    .decoded_instr_ack_o   (decoded_instr_ack_o),
    .issue_entry_o         (issue_entry_o),
    .issue_entry_valid_o   (issue_entry_valid_o),
    .is_ctrl_flow_o        (is_ctrl_flow_o),
    .issue_instr_ack_i     (issue_instr_ack_i),
    .peek_entry_o          (peek_entry_o),
    .peek_valid_o          (peek_valid_o),
    .count_o               (count_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic scoreboard_entry_t mk(input logic [63:0] pc);
    scoreboard_entry_t e;
    e = '0;
    e.pc = pc;
    e.rd = pc[6:2];
    e.valid = 1'b1;
    return e;
  endfunction

  // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic drive(input logic v, input logic [63:0] pc, input logic cf, input logic ack);
    decoded_instr_valid_i = v;
    decoded_instr_i       = mk(pc);
    is_ctrl_flow_i        = cf;
    issue_instr_ack_i     = ack;
    #1;
  endtask

  initial begin
    rst_ni = 1'b0; flush_i = 1'b0;
    decoded_instr_valid_i = 1'b0; decoded_instr_i = '0; is_ctrl_flow_i = 1'b0;
    issue_instr_ack_i = 1'b0;
    #12;
    chk("rst_count", 64'(count_o), 0);
    chk("rst_valid", 64'(issue_entry_valid_o), 0);
    chk("rst_peek_valid", 64'(peek_valid_o), 0);
    chk("rst_ack", 64'(decoded_instr_ack_o), 0);
    chk("rst_head_pc", issue_entry_o.pc, 0);
    @(negedge clk_i); rst_ni = 1'b1;
    step();

    // Push three entries, no pops. First one has the control-flow flag.
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 64'h100 + 64'(4*i), (i == 0), 1'b0);
      chk("push3_ack", 64'(decoded_instr_ack_o), 1);
      if (i == 0) chk("latency_valid", 64'(issue_entry_valid_o), 64'(BYP));
      step();
    end
    drive(1'b0, 0, 1'b0, 1'b0);
    chk("push3_count", 64'(count_o), 3);
    chk("push3_head", issue_entry_o.pc, 64'h100);
    chk("push3_cf", 64'(is_ctrl_flow_o), 1);
    chk("push3_peek", peek_entry_o.pc, 64'h104);
    chk("push3_peek_valid", 64'(peek_valid_o), 1);
    chk("push3_valid", 64'(issue_entry_valid_o), 1);

    // Fill to 4, then a 5th is refused.
    drive(1'b1, 64'h10c, 1'b0, 1'b0);
    chk("push4_ack", 64'(decoded_instr_ack_o), 1);
    step();
    drive(1'b1, 64'h110, 1'b0, 1'b0);
    chk("full_count", 64'(count_o), 4);
    chk("full_ack", 64'(decoded_instr_ack_o), 0);
    step();
    chk("full_hold", 64'(count_o), 4);
    // Full with push and pop together: pop only.
    drive(1'b1, 64'h110, 1'b0, 1'b1);
    chk("full_pushpop_ack", 64'(decoded_instr_ack_o), 0);
    step();
    drive(1'b1, 64'h110, 1'b0, 1'b0);
    chk("after_pop_count", 64'(count_o), 3);
    chk("after_pop_head", issue_entry_o.pc, 64'h104);
    chk("after_pop_ack", 64'(decoded_instr_ack_o), 1);
    step();
    drive(1'b0, 0, 1'b0, 1'b0);
    chk("refill_count", 64'(count_o), 4);

    // Drain: strict push order.
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 0, 1'b0, 1'b1);
      chk("drain_pc", issue_entry_o.pc, 64'h104 + 64'(4*i));
      step();
    end
    drive(1'b0, 0, 1'b0, 1'b1);
    chk("drained_count", 64'(count_o), 0);
    chk("drained_valid", 64'(issue_entry_valid_o), 0);
    step();
    drive(1'b0, 0, 1'b0, 1'b0);
    chk("empty_ack_ignored", 64'(count_o), 0);

    // Streaming push+pop for 10 entries.
    drive(1'b1, 64'h200, 1'b0, 1'b0);
    step();
    for (int i = 1; i <= 10; i++) begin
      drive(i < 10, 64'h200 + 64'(4*i), 1'b0, 1'b1);
      chk("stream_pc", issue_entry_o.pc, 64'h200 + 64'(4*(i-1)));
      chk("stream_count", 64'(count_o), 1);
      step();
    end
    drive(1'b0, 0, 1'b0, 1'b0);
    chk("stream_end_count", 64'(count_o), 0);

    // Flush with count 3, valid and ack asserted.
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 64'h400 + 64'(4*i), 1'b0, 1'b0);
      step();
    end
    flush_i = 1'b1;
    drive(1'b1, 64'h40c, 1'b0, 1'b1);
    chk("flush_ack", 64'(decoded_instr_ack_o), 0);
    step();
    flush_i = 1'b0;
    drive(1'b0, 0, 1'b0, 1'b0);
    chk("flush_count", 64'(count_o), 0);
    chk("flush_valid", 64'(issue_entry_valid_o), 0);
    drive(1'b1, 64'h500, 1'b0, 1'b0);
    step();
    drive(1'b0, 0, 1'b0, 1'b0);
    chk("post_flush_head", issue_entry_o.pc, 64'h500);
    chk("post_flush_count", 64'(count_o), 1);
    drive(1'b0, 0, 1'b0, 1'b1);
    step();
    drive(1'b0, 0, 1'b0, 1'b0);

    // Empty queue, decoder valid and issue ack in the same cycle.
    drive(1'b1, 64'h300, 1'b1, 1'b1);
    chk("byp_ack", 64'(decoded_instr_ack_o), 1);
    chk("byp_valid", 64'(issue_entry_valid_o), 64'(BYP));
    if (BYP) chk("byp_pc", issue_entry_o.pc, 64'h300);
    step();
    drive(1'b0, 0, 1'b0, 1'b0);
    chk("byp_count", 64'(count_o), BYP ? 0 : 1);
    if (!BYP) begin
      chk("nobyp_head", issue_entry_o.pc, 64'h300);
      drive(1'b0, 0, 1'b0, 1'b1);
      step();
      drive(1'b0, 0, 1'b0, 1'b0);
    end

    // Asynchronous reset mid-operation.
    drive(1'b1, 64'h600, 1'b0, 1'b0);
    step();
    step();
    drive(1'b0, 0, 1'b0, 1'b0);
    chk("pre_rst_count", 64'(count_o), 2);
    #2 rst_ni = 1'b0;
    #1;
    chk("async_rst_count", 64'(count_o), 0);
    chk("async_rst_valid", 64'(issue_entry_valid_o), 0);
    @(negedge clk_i); rst_ni = 1'b1;
    step();

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
